capture_signature_unit: RTL and testbench



---
 rtl/capture_pkg.sv | 22 ++
 rtl/capture_buffer_ram.sv | 30 +++
 rtl/capture_signature_unit.sv | 100 ++++++++++
 tb/tb_capture_signature_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and constants for the capture/signature block.
// rot_xor is the single definition of the rotate-XOR signature step.
package capture_pkg;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } cap_state_t;

   function automatic logic [DATA_W-1:0] rot_xor(input logic [DATA_W-1:0] sig,
                                                 input logic [DATA_W-1:0] d);
      return {sig[DATA_W-2:0], sig[DATA_W-1]} ^ d;
   endfunction

endpackage

// File: rtl/capture_buffer_ram.sv
// DEPTH x DATA_W sample buffer: one synchronous write port, one registered read port.
// Contents are intentionally not reset.
module capture_buffer_ram
   import capture_pkg::*;
(
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Same-address read and write on one edge returns the previous contents.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/capture_signature_unit.sv
// Captures a window of up to DEPTH samples and keeps sum and rotate-XOR signatures.
//   state   | meaning
//   IDLE    | waiting for start, no writes
//   CAPTURE | writing one sample per cycle, signatures accumulating
//   DONE    | window closed, count/signatures held until restart
module capture_signature_unit
   import capture_pkg::*;
(
   input  logic              clk,
   input  logic              clear,
   input  logic              start,
   input  logic              stop,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   sample_count,
   output logic [DATA_W-1:0] sum_sig,
   output logic [DATA_W-1:0] rot_sig
);

   cap_state_t        state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic [DATA_W-1:0] rot_q, rot_d;
   logic              rd_hit_q, rd_hit_d;
   logic              wr_en;
   logic [DATA_W-1:0] ram_rdata;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      sum_d    = sum_q;
      rot_d    = rot_q;
      wr_en    = 1'b0;
      rd_hit_d = rd_hit_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = CAPTURE;
               count_d = '0;
               sum_d   = '0;
               rot_d   = '0;
            end
         end
         CAPTURE: begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
            sum_d   = sum_q + data_in;
            rot_d   = rot_xor(rot_q, data_in);
            if (stop || (count_q == LAST_CNT)) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Entries beyond the current window read back as zero.
      if (rd_en) begin
         rd_hit_d = ({1'b0, rd_addr} < count_q);
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q  <= IDLE;
         count_q  <= '0;
         sum_q    <= '0;
         rot_q    <= '0;
         rd_hit_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         sum_q    <= sum_d;
         rot_q    <= rot_d;
         rd_hit_q <= rd_hit_d;
      end
   end

   capture_buffer_ram u_ram (
      .clk     (clk),
      .we_i    (wr_en & ~clear),
      .waddr_i (count_q[ADDR_W-1:0]),
      .wdata_i (data_in),
      .re_i    (rd_en),
      .raddr_i (rd_addr),
      .rdata_o (ram_rdata)
   );

   assign rd_data      = rd_hit_q ? ram_rdata : '0;
   assign busy         = (state_q == CAPTURE);
   assign done         = (state_q == DONE);
   assign sample_count = count_q;
   assign sum_sig      = sum_q;
   assign rot_sig      = rot_q;

endmodule

// File: tb/tb_capture_signature_unit.sv
// Directed bench for capture_signature_unit with hand-computed expectations.
module tb_capture_signature_unit;

   logic       clk;
   logic       clear;
   logic       start;
   logic       stop;
   logic [7:0] data_in;
   logic       rd_en;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       busy;
   logic       done;
   logic [4:0] sample_count;
   logic [7:0] sum_sig;
   logic [7:0] rot_sig;

   int total;
   int bad;

   capture_signature_unit dut (
      .clk          (clk),
      .clear        (clear),
      .start        (start),
      .stop         (stop),
      .data_in      (data_in),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .busy         (busy),
      .done         (done),
      .sample_count (sample_count),
      .sum_sig      (sum_sig),
      .rot_sig      (rot_sig)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_status(input string tag, input logic b, input logic d,
                             input logic [4:0] cnt, input logic [7:0] s, input logic [7:0] r);
      chk({tag, ".busy"}, 32'(busy), 32'(b));
      chk({tag, ".done"}, 32'(done), 32'(d));
      chk({tag, ".count"}, 32'(sample_count), 32'(cnt));
      chk({tag, ".sum"}, 32'(sum_sig), 32'(s));
      chk({tag, ".rot"}, 32'(rot_sig), 32'(r));
   endtask

   task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      rd_en   = 1'b0;
      chk(tag, 32'(rd_data), 32'(exp));
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      clear   = 1'b1;
      start   = 1'b0;
      stop    = 1'b0;
      data_in = 8'h00;
      rd_en   = 1'b0;
      rd_addr = 4'd0;

      // 1: reset and idle, stop in IDLE ignored
      tick();
      tick();
      clear = 1'b0;
      for (int i = 0; i < 5; i++) begin
         data_in = (i % 2 == 0) ? 8'hA5 : 8'h5A;
         stop    = (i == 2);
         tick();
      end
      stop = 1'b0;
      chk_status("idle", 1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
      chk("idle.rd_data", 32'(rd_data), 32'h0);

      // 2: full window of 0x01
      start = 1'b1;
      tick();
      start = 1'b0;
      chk_status("s2.start", 1'b1, 1'b0, 5'd0, 8'h00, 8'h00);
      data_in = 8'h01;
      for (int i = 0; i < 15; i++) tick();
      chk("s2.busy15", 32'(busy), 32'h1);
      chk("s2.cnt15", 32'(sample_count), 32'd15);
      tick();
      chk_status("s2.full", 1'b0, 1'b1, 5'd16, 8'h10, 8'h00);
      tick();
      chk_status("s2.hold", 1'b0, 1'b1, 5'd16, 8'h10, 8'h00);

      // 6: restart from DONE, start during CAPTURE ignored
      start   = 1'b1;
      data_in = 8'hFF;
      tick();
      start = 1'b0;
      chk_status("s6.restart", 1'b1, 1'b0, 5'd0, 8'h00, 8'h00);
      for (int i = 0; i < 8; i++) begin
         start = (i == 4);
         tick();
      end
      start = 1'b0;
      chk_status("s6.mid", 1'b1, 1'b0, 5'd8, 8'hF8, 8'h00);
      for (int i = 0; i < 8; i++) tick();
      chk_status("s6.full", 1'b0, 1'b1, 5'd16, 8'hF0, 8'h00);

      // 3: ramp window and readback
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         data_in = 8'(i);
         tick();
      end
      chk("s3.done", 32'(done), 32'h1);
      chk("s3.count", 32'(sample_count), 32'd16);
      chk("s3.sum", 32'(sum_sig), 32'h78);
      for (int i = 0; i < 16; i++) begin
         read_chk($sformatf("s3.rd%0d", i), 4'(i), 8'(i));
      end
      tick();
      chk("s3.rd_hold", 32'(rd_data), 32'd15);

      // 4: early stop after five samples
      start = 1'b1;
      tick();
      start = 1'b0;
      data_in = 8'h11; tick();
      data_in = 8'h22; tick();
      data_in = 8'h33; tick();
      data_in = 8'h44; tick();
      data_in = 8'h55; stop = 1'b1; tick();
      stop = 1'b0;
      chk_status("s4.stop", 1'b0, 1'b1, 5'd5, 8'hFF, 8'h11);
      tick();
      chk("s4.hold_cnt", 32'(sample_count), 32'd5);
      read_chk("s4.rd7", 4'd7, 8'h00);
      read_chk("s4.rd4", 4'd4, 8'h55);
      read_chk("s4.rd5", 4'd5, 8'h00);
      read_chk("s4.rd0", 4'd0, 8'h11);

      // 5: clear mid-capture, then a fresh window from entry 0
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         data_in = 8'h60 + 8'(i);
         tick();
      end
      chk("s5.pre_cnt", 32'(sample_count), 32'd6);
      clear = 1'b1;
      rd_en = 1'b1;
      rd_addr = 4'd0;
      tick();
      clear = 1'b0;
      rd_en = 1'b0;
      chk_status("s5.clear", 1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
      chk("s5.rd_clr", 32'(rd_data), 32'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      data_in = 8'hA0; tick();
      data_in = 8'h0B; stop = 1'b1; tick();
      stop = 1'b0;
      chk_status("s5.new", 1'b0, 1'b1, 5'd2, 8'hAB, 8'h4A);
      read_chk("s5.rd0", 4'd0, 8'hA0);
      read_chk("s5.rd1", 4'd1, 8'h0B);
      read_chk("s5.rd2", 4'd2, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
